spi_txn_ctrl: RTL and testbench

SPI_TXN_CTRL -- requirements
Module: spi_txn_ctrl

---
 rtl/spi_txn_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_spi_txn_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// spi_txn_ctrl : host TX/RX byte FIFOs driving one SPI master transfer at a time
// Revision     : 1.0
// ============================================================================
module spi_txn_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wr,
  input  logic [7:0] tx_data,
  output logic       tx_full,
  input  logic       rx_rd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       m_newd,
  output logic [7:0] m_din,
  input  logic       m_cs,
  input  logic [7:0] m_dout,
  output logic       busy,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
  localparam logic [TW-1:0] WAIT_MAX = TIMEOUT[TW-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            m_newd_q, m_newd_d;
  logic [7:0]      m_din_q, m_din_d;
  logic            err_q, err_d;
  logic [TW-1:0]   wait_q, wait_d;
  logic            armed_q, armed_d;
  logic            m_cs_q, m_cs_d;
  logic [7:0]      m_dout_q, m_dout_d;

  logic [7:0]      tx_mem_q [DEPTH];
  logic [7:0]      tx_mem_d [DEPTH];
  logic [AW-1:0]   tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW:0]     tx_cnt_q, tx_cnt_d;
  logic [7:0]      rx_mem_q [DEPTH];
  logic [7:0]      rx_mem_d [DEPTH];
  logic [AW-1:0]   rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0]     rx_cnt_q, rx_cnt_d;

  logic            tx_push, tx_pop, rx_push, rx_pop;

  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_valid = (rx_cnt_q != '0);
  assign rx_data  = rx_valid ? rx_mem_q[rx_rp_q] : 8'h00;
  assign m_newd   = m_newd_q;
  assign m_din    = m_din_q;
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

  // Controller. armed_q blocks new requests after reset until the master is
  // seen idle, so a transfer that survived the reset cannot be mistaken for ours.
  always_comb begin
    state_d  = state_q;
    m_newd_d = m_newd_q;
    m_din_d  = m_din_q;
    err_d    = err_q;
    wait_d   = wait_q;
    armed_d  = armed_q;
    m_cs_d   = m_cs;
    m_dout_d = m_dout;
    tx_pop   = 1'b0;
    rx_push  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (m_cs) armed_d = 1'b1;
        // Starting only with a free RX slot keeps the BUSY-state push from overflowing.
        if (armed_q && !err_q && (tx_cnt_q != '0) && (rx_cnt_q != FULL_CNT)) begin
          state_d  = S_REQ;
          tx_pop   = 1'b1;
          m_din_d  = tx_mem_q[tx_rp_q];
          m_newd_d = 1'b1;
          wait_d   = '0;
        end
      end
      S_REQ: begin
        if (!m_cs) begin
          state_d  = S_BUSY;
          m_newd_d = 1'b0;
        end else begin
          wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
          if (wait_d == WAIT_MAX) begin
            state_d  = S_ERR;
            err_d    = 1'b1;
            m_newd_d = 1'b0;
          end
        end
      end
      S_BUSY: begin
        if (m_cs && !m_cs_q) begin
          rx_push = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    tx_push  = tx_wr && !tx_full;
    rx_pop   = rx_rd && rx_valid;
    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    rx_cnt_d = rx_cnt_q;
    if (tx_push) begin
      tx_mem_d[tx_wp_q] = tx_data;
      tx_wp_d           = tx_wp_q + 1'b1;
    end
    if (tx_pop) tx_rp_d = tx_rp_q + 1'b1;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
    else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - 1'b1;
    if (rx_push) begin
      rx_mem_d[rx_wp_q] = m_dout_q;
      rx_wp_d           = rx_wp_q + 1'b1;
    end
    if (rx_pop) rx_rp_d = rx_rp_q + 1'b1;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      m_newd_q <= 1'b0;
      m_din_q  <= 8'h00;
      err_q    <= 1'b0;
      wait_q   <= '0;
      armed_q  <= 1'b0;
      m_cs_q   <= 1'b1;
      m_dout_q <= 8'h00;
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tx_mem_q[i] <= 8'h00;
        rx_mem_q[i] <= 8'h00;
      end
    end else begin
      state_q  <= state_d;
      m_newd_q <= m_newd_d;
      m_din_q  <= m_din_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      armed_q  <= armed_d;
      m_cs_q   <= m_cs_d;
      m_dout_q <= m_dout_d;
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      rx_cnt_q <= rx_cnt_d;
      tx_mem_q <= tx_mem_d;
      rx_mem_q <= rx_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_ctrl.sv
`default_nettype none
// ============================================================================
// tb_spi_txn_ctrl : directed bench with an SPI master + echoing slave model
// Revision        : 1.0
// ============================================================================
module tb_spi_txn_ctrl;

  localparam int TO = 10;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic       tx_wr   = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       rx_rd   = 1'b0;
  logic       m_cs    = 1'b1;
  logic [7:0] m_dout  = 8'h00;
  logic       tx_full, rx_valid, m_newd, busy, err;
  logic [7:0] rx_data, m_din;

  int         n_checks = 0;
  int         n_errors = 0;
  logic       model_en = 1'b1;
  int         hold_cycles = 3;
  logic [7:0] slave_q = 8'h00;
  logic [7:0] req_log [$];
  logic [7:0] exp_q [$];
  logic       newd_prev = 1'b0;

  always #5 clk = ~clk;

  spi_txn_ctrl #(.DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_valid(rx_valid),
    .m_newd(m_newd), .m_din(m_din), .m_cs(m_cs), .m_dout(m_dout),
    .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Master answers a request by lowering chip-select for hold_cycles; the
  // slave returns the byte it received on the previous transfer.
  initial begin : spi_master
    logic [7:0] latched;
    forever begin
      @(negedge clk);
      if (model_en && m_newd && m_cs) begin
        latched = m_din;
        m_dout  = slave_q;
        m_cs    = 1'b0;
        repeat (hold_cycles) @(negedge clk);
        m_cs    = 1'b1;
        slave_q = latched;
      end
    end
  end

  always @(negedge clk) begin
    if (m_newd && !newd_prev) req_log.push_back(m_din);
    newd_prev = m_newd;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data = b;
    tx_wr   = 1'b1;
    tick();
    tx_wr   = 1'b0;
  endtask

  task automatic pop();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
  endtask

  task automatic wait_rx(input string tag);
    int n = 0;
    while (!rx_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_wait"}, rx_valid, 1);
  endtask

  task automatic wait_busy_state(input string tag);
    int n = 0;
    while (!(busy && !m_newd) && n < 20) begin
      tick();
      n++;
    end
    check(tag, busy && !m_newd, 1);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() != 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      wait_rx(tag);
      check(tag, rx_data, e);
      pop();
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int  base;
    int  n;
    logic early;

    // Reset values
    repeat (3) tick();
    check("rst_tx_full", tx_full, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_m_newd", m_newd, 0);
    check("rst_m_din", m_din, 8'h00);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Single byte with loopback
    push(8'hA5);
    check("single_newd_early", m_newd, 0);
    tick();
    check("single_newd_rise", m_newd, 1);
    check("single_din", m_din, 8'hA5);
    check("single_busy", busy, 1);
    tick();
    check("single_newd_fall", m_newd, 0);
    check("single_busy_xfer", busy, 1);
    tick();
    tick();
    check("single_rx_before_rise", rx_valid, 0);
    tick();
    check("single_rx_valid", rx_valid, 1);
    check("single_rx_first", rx_data, 8'h00);
    check("single_idle", busy, 0);
    pop();
    check("single_rx_popped", rx_valid, 0);
    push(8'h3C);
    exp_q = '{8'hA5};
    drain("single_echo");
    repeat (20) tick();
    check("single_rx_empty", rx_valid, 0);

    // RX backpressure then burst into a blocked TX FIFO
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    repeat (40) tick();
    check("bp_rx_valid", rx_valid, 1);
    check("bp_idle", busy, 0);
    base = req_log.size();
    push(8'h01); push(8'h02); push(8'h03);
    check("burst_not_full_3", tx_full, 0);
    push(8'h04);
    check("burst_full", tx_full, 1);
    push(8'h05);
    check("burst_full_after_drop", tx_full, 1);
    repeat (10) tick();
    check("bp_hold_idle", busy, 0);
    check("bp_no_req", req_log.size() - base, 0);
    check("bp_head", rx_data, 8'h3C);
    pop();
    repeat (15) tick();
    check("bp_one_req", req_log.size() - base, 1);
    check("bp_blocked_again", busy, 0);
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h01, 8'h02, 8'h03};
    drain("bp_drain");
    repeat (20) tick();
    check("burst_req_count", req_log.size() - base, 4);
    for (int i = 0; i < 4; i++) check("burst_din_order", req_log[base + i], i + 1);
    check("burst_rx_empty", rx_valid, 0);

    // RX push and pop together at occupancy 2
    push(8'hB1); push(8'hB2);
    repeat (20) tick();
    check("sim_rx_pre", rx_data, 8'h04);
    push(8'hB3);
    wait_busy_state("sim_rx_busy");
    tick();
    tick();
    rx_rd = 1'b1;
    tick();
    rx_rd = 1'b0;
    check("sim_rx_idle", busy, 0);
    check("sim_rx_head", rx_data, 8'hB1);
    pop();
    check("sim_rx_second", rx_data, 8'hB2);
    pop();
    check("sim_rx_empty", rx_valid, 0);

    // TX push and pop together at occupancy 2
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    repeat (40) tick();
    push(8'hD1); push(8'hD2);
    rx_rd = 1'b1;
    tick();
    rx_rd   = 1'b0;
    tx_data = 8'hD3;
    tx_wr   = 1'b1;
    tick();
    tx_wr   = 1'b0;
    check("sim_tx_req", m_newd, 1);
    check("sim_tx_din", m_din, 8'hD1);
    repeat (15) tick();
    check("sim_tx_blocked", busy, 0);
    push(8'hD4);
    check("sim_tx_not_full", tx_full, 0);
    push(8'hD5);
    check("sim_tx_full", tx_full, 1);
    exp_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    drain("sim_tx_drain");
    repeat (30) tick();
    check("sim_tx_rx_empty", rx_valid, 0);

    // Reset during a transfer; the surviving chip-select rise must be ignored
    hold_cycles = 8;
    push(8'hE1);
    wait_busy_state("rstx_busy");
    rst = 1'b1;
    hold_cycles = 3;
    tick();
    check("rstx_busy_clr", busy, 0);
    check("rstx_newd", m_newd, 0);
    check("rstx_din", m_din, 8'h00);
    check("rstx_rx_valid", rx_valid, 0);
    check("rstx_rx_data", rx_data, 8'h00);
    check("rstx_err", err, 0);
    check("rstx_tx_full", tx_full, 0);
    rst = 1'b0;
    push(8'hE2);
    n = 0;
    early = 1'b0;
    while (!m_cs && n < 20) begin
      if (m_newd) early = 1'b1;
      tick();
      n++;
    end
    check("rstx_cs_rise_seen", m_cs, 1);
    check("rstx_no_req_cs_low", early, 0);
    check("rstx_no_rx_old_rise", rx_valid, 0);
    tick();
    check("rstx_no_rx_after", rx_valid, 0);
    exp_q = '{8'hE1};
    drain("rstx_resume");
    repeat (20) tick();

    // Timeout with chip-select held high
    model_en = 1'b0;
    base = req_log.size();
    push(8'h55);
    n = 0;
    while (!m_newd && n < 10) begin
      tick();
      n++;
    end
    check("to_req", m_newd, 1);
    n = 0;
    while (!err && n < 30) begin
      tick();
      n++;
    end
    check("to_cycles", n, TO);
    check("to_err", err, 1);
    check("to_newd_low", m_newd, 0);
    check("to_busy", busy, 1);
    push(8'h66);
    push(8'h77);
    repeat (20) tick();
    check("to_no_new_req", req_log.size() - base, 1);
    check("to_newd_stays_low", m_newd, 0);
    check("to_err_sticky", err, 1);

    rst = 1'b1;
    tick();
    check("final_rst_err", err, 0);
    check("final_rst_busy", busy, 0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
